// File: rtl/lc3_ctrl_fsm.sv
// LC-3 control-unit FSM: fetch, decode and execute sequencing for the LC-3 datapath.
// The FSM is Moore. The exceptions are ld_mdr in the memory wait states, which
// follows mem_ready, and the branch load in BR, which follows ben.
// All outputs are held at 0 from reset until the first clock edge after rst rises.
// Optional feature: define LC3_CTRL_TRAP_EN to add the TRAP sequence T0..T3.
// If it is undefined, opcode 1111 traps to ILL.
// state_o debug encoding:
//   F1=0 F2=1 F3=2 DEC=3 ALU=4 BR=5 JMP=6 JSR0=7 JSR1=8 LA=9 LR=10 LW=11
//   SA=12 SD=13 SW=14 LEA=15 ILL=16 T0=17 T1=18 T2=19 T3=20
module lc3_ctrl_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        ben,
  input  logic        mem_ready,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_pc,
  output logic        ld_reg,
  output logic        ld_cc,
  output logic        ld_ben,
  output logic        gate_pc,
  output logic        gate_mdr,
  output logic        gate_alu,
  output logic        gate_marmux,
  output logic [1:0]  drmux,
  output logic [1:0]  sr1mux,
  output logic [1:0]  pcmux,
  output logic        addr1mux,
  output logic [1:0]  addr2mux,
  output logic        marmux,
  output logic [1:0]  aluk,
  output logic        mio_en,
  output logic        r_w,
  output logic        illegal,
  output logic [4:0]  state_o
);

  localparam logic [4:0] S_F1   = 5'd0;
  localparam logic [4:0] S_F2   = 5'd1;
  localparam logic [4:0] S_F3   = 5'd2;
  localparam logic [4:0] S_DEC  = 5'd3;
  localparam logic [4:0] S_ALU  = 5'd4;
  localparam logic [4:0] S_BR   = 5'd5;
  localparam logic [4:0] S_JMP  = 5'd6;
  localparam logic [4:0] S_JSR0 = 5'd7;
  localparam logic [4:0] S_JSR1 = 5'd8;
  localparam logic [4:0] S_LA   = 5'd9;
  localparam logic [4:0] S_LR   = 5'd10;
  localparam logic [4:0] S_LW   = 5'd11;
  localparam logic [4:0] S_SA   = 5'd12;
  localparam logic [4:0] S_SD   = 5'd13;
  localparam logic [4:0] S_SW   = 5'd14;
  localparam logic [4:0] S_LEA  = 5'd15;
  localparam logic [4:0] S_ILL  = 5'd16;
`ifdef LC3_CTRL_TRAP_EN
  localparam logic [4:0] S_T0   = 5'd17;
  localparam logic [4:0] S_T1   = 5'd18;
  localparam logic [4:0] S_T2   = 5'd19;
  localparam logic [4:0] S_T3   = 5'd20;
`endif

  logic [4:0] state_q, state_d;
  logic       run_q;   // low from reset until the first edge after release; gates all outputs
  logic [3:0] opcode;
  logic       unused_ir;

  assign opcode    = ir[15:12];
  assign state_o   = state_q;
  assign unused_ir = ^ir[10:0];

  // State register; reset parks the FSM in F1 with outputs suppressed.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_F1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Next-state and control decode from the current state.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    ld_mar      = 1'b0;
    ld_mdr      = 1'b0;
    ld_ir       = 1'b0;
    ld_pc       = 1'b0;
    ld_reg      = 1'b0;
    ld_cc       = 1'b0;
    ld_ben      = 1'b0;
    gate_pc     = 1'b0;
    gate_mdr    = 1'b0;
    gate_alu    = 1'b0;
    gate_marmux = 1'b0;
    drmux       = 2'b00;
    sr1mux      = 2'b00;
    pcmux       = 2'b00;
    addr1mux    = 1'b0;
    addr2mux    = 2'b00;
    marmux      = 1'b0;
    aluk        = 2'b00;
    mio_en      = 1'b0;
    r_w         = 1'b0;
    illegal     = 1'b0;
    if (run_q) begin
      case (state_q)
        S_F1: begin
          gate_pc = 1'b1;
          ld_mar  = 1'b1;
          ld_pc   = 1'b1;
          state_d = S_F2;
        end
        S_F2: begin
          mio_en = 1'b1;
          ld_mdr = mem_ready;
          if (mem_ready) state_d = S_F3;
        end
        S_F3: begin
          gate_mdr = 1'b1;
          ld_ir    = 1'b1;
          state_d  = S_DEC;
        end
        S_DEC: begin
          ld_ben = 1'b1;
          case (opcode)
            4'b0001, 4'b0101, 4'b1001: state_d = S_ALU;
            4'b0000:                   state_d = S_BR;
            4'b1100:                   state_d = S_JMP;
            4'b0100:                   state_d = S_JSR0;
            4'b0010, 4'b0110:          state_d = S_LA;
            4'b0011, 4'b0111:          state_d = S_SA;
            4'b1110:                   state_d = S_LEA;
`ifdef LC3_CTRL_TRAP_EN
            4'b1111:                   state_d = S_T0;
`endif
            default:                   state_d = S_ILL;
          endcase
        end
        S_ALU: begin
          gate_alu = 1'b1;
          ld_reg   = 1'b1;
          ld_cc    = 1'b1;
          sr1mux   = 2'b01;
          case (opcode)
            4'b0101: aluk = 2'b01;
            4'b1001: aluk = 2'b10;
            default: aluk = 2'b00;
          endcase
          state_d = S_F1;
        end
        S_BR: begin
          if (ben) begin
            ld_pc    = 1'b1;
            pcmux    = 2'b10;
            addr2mux = 2'b10;
          end
          state_d = S_F1;
        end
        S_JMP: begin
          ld_pc    = 1'b1;
          pcmux    = 2'b10;
          addr1mux = 1'b1;
          sr1mux   = 2'b01;
          state_d  = S_F1;
        end
        S_JSR0: begin
          gate_pc = 1'b1;
          ld_reg  = 1'b1;
          drmux   = 2'b01;
          state_d = S_JSR1;
        end
        S_JSR1: begin
          ld_pc = 1'b1;
          pcmux = 2'b10;
          if (ir[11]) begin
            addr2mux = 2'b11;
          end else begin
            addr1mux = 1'b1;
            sr1mux   = 2'b01;
          end
          state_d = S_F1;
        end
        // Load and store share address generation; opcode bit 2 selects base+offset6.
        S_LA, S_SA: begin
          gate_marmux = 1'b1;
          marmux      = 1'b1;
          ld_mar      = 1'b1;
          if (opcode[2]) begin
            addr1mux = 1'b1;
            sr1mux   = 2'b01;
            addr2mux = 2'b01;
          end else begin
            addr2mux = 2'b10;
          end
          state_d = (state_q == S_LA) ? S_LR : S_SD;
        end
        S_LR: begin
          mio_en = 1'b1;
          ld_mdr = mem_ready;
          if (mem_ready) state_d = S_LW;
        end
        S_LW: begin
          gate_mdr = 1'b1;
          ld_reg   = 1'b1;
          ld_cc    = 1'b1;
          state_d  = S_F1;
        end
        S_SD: begin
          aluk     = 2'b11;
          gate_alu = 1'b1;
          ld_mdr   = 1'b1;
          state_d  = S_SW;
        end
        S_SW: begin
          mio_en = 1'b1;
          r_w    = 1'b1;
          if (mem_ready) state_d = S_F1;
        end
        S_LEA: begin
          gate_marmux = 1'b1;
          marmux      = 1'b1;
          addr2mux    = 2'b10;
          ld_reg      = 1'b1;
          state_d     = S_F1;
        end
`ifdef LC3_CTRL_TRAP_EN
        S_T0: begin
          gate_pc = 1'b1;
          ld_reg  = 1'b1;
          drmux   = 2'b01;
          state_d = S_T1;
        end
        S_T1: begin
          gate_marmux = 1'b1;
          ld_mar      = 1'b1;
          state_d     = S_T2;
        end
        S_T2: begin
          mio_en = 1'b1;
          ld_mdr = mem_ready;
          if (mem_ready) state_d = S_T3;
        end
        S_T3: begin
          gate_mdr = 1'b1;
          pcmux    = 2'b01;
          ld_pc    = 1'b1;
          state_d  = S_F1;
        end
`endif
        S_ILL: illegal = 1'b1;
        default: state_d = S_F1;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Scoreboard bench for lc3_ctrl_fsm. An instruction-level model expands each
// instruction into its expected per-cycle control words. A driver applies the
// stimulus and pushes the expected word. A monitor pops and compares on the falling edge.
module tb_lc3_ctrl_fsm;

  localparam logic [4:0] ST_F1 = 5'd0,  ST_F2 = 5'd1,  ST_F3 = 5'd2,  ST_DEC = 5'd3;
  localparam logic [4:0] ST_ALU = 5'd4, ST_BR = 5'd5,  ST_JMP = 5'd6, ST_JSR0 = 5'd7;
  localparam logic [4:0] ST_JSR1 = 5'd8, ST_LA = 5'd9, ST_LR = 5'd10, ST_LW = 5'd11;
  localparam logic [4:0] ST_SA = 5'd12, ST_SD = 5'd13, ST_SW = 5'd14, ST_LEA = 5'd15;
  localparam logic [4:0] ST_ILL = 5'd16, ST_T0 = 5'd17, ST_T1 = 5'd18, ST_T2 = 5'd19;
  localparam logic [4:0] ST_T3 = 5'd20;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] drmux, sr1mux, pcmux;
    logic addr1mux;
    logic [1:0] addr2mux;
    logic marmux;
    logic [1:0] aluk;
    logic mio_en, r_w, illegal;
  } ctl_t;

  typedef struct packed {
    logic [15:0] ir;
    logic        ben;
    logic        mr;
    logic [4:0]  st;
    ctl_t        c;
  } cyc_t;

  typedef struct packed {
    logic [4:0] st;
    ctl_t       c;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0, ben = 1'b0, mem_ready = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben;
  logic gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic [1:0] drmux, sr1mux, pcmux, addr2mux, aluk;
  logic addr1mux, marmux, mio_en, r_w, illegal;
  logic [4:0] state_o;
  ctl_t act_c;

  int checks = 0, failures = 0;
  cyc_t cyc_q[$];
  exp_t exp_q[$];
  logic [15:0] cur_ir;
  logic        cur_ben;

  lc3_ctrl_fsm dut (
    .clk(clk), .rst(rst), .ir(ir), .ben(ben), .mem_ready(mem_ready),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_pc(ld_pc), .ld_reg(ld_reg),
    .ld_cc(ld_cc), .ld_ben(ld_ben), .gate_pc(gate_pc), .gate_mdr(gate_mdr),
    .gate_alu(gate_alu), .gate_marmux(gate_marmux), .drmux(drmux), .sr1mux(sr1mux),
    .pcmux(pcmux), .addr1mux(addr1mux), .addr2mux(addr2mux), .marmux(marmux),
    .aluk(aluk), .mio_en(mio_en), .r_w(r_w), .illegal(illegal), .state_o(state_o)
  );

  assign act_c = {ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben,
                  gate_pc, gate_mdr, gate_alu, gate_marmux, drmux, sr1mux, pcmux,
                  addr1mux, addr2mux, marmux, aluk, mio_en, r_w, illegal};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [4:0] st, input ctl_t c, input logic mr);
    cyc_t r;
    r.ir = cur_ir; r.ben = cur_ben; r.mr = mr; r.st = st; r.c = c;
    cyc_q.push_back(r);
  endtask

  // A memory read cycle group: waits cycles without ready, then one ready cycle that loads MDR.
  task automatic mem_read(input logic [4:0] st, input int waits);
    ctl_t c = '0;
    c.mio_en = 1'b1;
    for (int i = 0; i < waits; i++) push(st, c, 1'b0);
    c.ld_mdr = 1'b1;
    push(st, c, 1'b1);
  endtask

  // Instruction-level reference: the expected control words for one full instruction.
  task automatic gen_instr(input logic [15:0] ir_v, input logic ben_v,
                           input int wf, input int wm, input bit sw_abort);
    ctl_t c;
    logic [3:0] op = ir_v[15:12];
    cur_ir = ir_v; cur_ben = ben_v;
    c = '0; c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1;            push(ST_F1, c, rnd());
    mem_read(ST_F2, wf);
    c = '0; c.gate_mdr = 1; c.ld_ir = 1;                          push(ST_F3, c, rnd());
    c = '0; c.ld_ben = 1;                                         push(ST_DEC, c, rnd());
    c = '0;
    case (op)
      4'h1, 4'h5, 4'h9: begin
        c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.sr1mux = 2'b01;
        c.aluk = (op == 4'h1) ? 2'b00 : (op == 4'h5) ? 2'b01 : 2'b10;
        push(ST_ALU, c, rnd());
      end
      4'h0: begin
        if (ben_v) begin c.ld_pc = 1; c.pcmux = 2'b10; c.addr2mux = 2'b10; end
        push(ST_BR, c, rnd());
      end
      4'hC: begin
        c.ld_pc = 1; c.pcmux = 2'b10; c.addr1mux = 1; c.sr1mux = 2'b01;
        push(ST_JMP, c, rnd());
      end
      4'h4: begin
        c.gate_pc = 1; c.ld_reg = 1; c.drmux = 2'b01;             push(ST_JSR0, c, rnd());
        c = '0; c.ld_pc = 1; c.pcmux = 2'b10;
        if (ir_v[11]) c.addr2mux = 2'b11;
        else begin c.addr1mux = 1; c.sr1mux = 2'b01; end
        push(ST_JSR1, c, rnd());
      end
      4'h2, 4'h6, 4'h3, 4'h7: begin
        c.gate_marmux = 1; c.marmux = 1; c.ld_mar = 1;
        if (op == 4'h6 || op == 4'h7) begin c.addr1mux = 1; c.sr1mux = 2'b01; c.addr2mux = 2'b01; end
        else c.addr2mux = 2'b10;
        if (op == 4'h2 || op == 4'h6) begin
          push(ST_LA, c, rnd());
          mem_read(ST_LR, wm);
          c = '0; c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1;      push(ST_LW, c, rnd());
        end else begin
          push(ST_SA, c, rnd());
          c = '0; c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1;   push(ST_SD, c, rnd());
          c = '0; c.mio_en = 1; c.r_w = 1;
          for (int i = 0; i < wm; i++) push(ST_SW, c, 1'b0);
          if (!sw_abort) push(ST_SW, c, 1'b1);
        end
      end
      4'hE: begin
        c.gate_marmux = 1; c.marmux = 1; c.addr2mux = 2'b10; c.ld_reg = 1;
        push(ST_LEA, c, rnd());
      end
`ifdef LC3_CTRL_TRAP_EN
      4'hF: begin
        c.gate_pc = 1; c.ld_reg = 1; c.drmux = 2'b01;             push(ST_T0, c, rnd());
        c = '0; c.gate_marmux = 1; c.ld_mar = 1;                  push(ST_T1, c, rnd());
        mem_read(ST_T2, wm);
        c = '0; c.gate_mdr = 1; c.pcmux = 2'b01; c.ld_pc = 1;     push(ST_T3, c, rnd());
      end
`endif
      default: begin
        c.illegal = 1;
        for (int i = 0; i < 10; i++) push(ST_ILL, c, rnd());
      end
    endcase
  endtask

  // Wait, with a cycle budget, until all issued stimulus has been checked.
  task automatic drain();
    int n = 0;
    while ((cyc_q.size() != 0 || exp_q.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    #2;
    if (n >= 20000) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", cyc_q.size() + exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 32'(act_c), 32'(0));
    check({tag, "_state"}, 32'(state_o), 32'(ST_F1));
  endtask

  // Driver: applies one cycle of stimulus after each rising edge and records its expectation.
  initial begin : driver
    cyc_t r;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() != 0) begin
        r = cyc_q.pop_front();
        ir = r.ir; ben = r.ben; mem_ready = r.mr;
        exp_q.push_back({r.st, r.c});
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  // Monitor: compares the DUT against the oldest expectation on each falling edge.
  initial begin : monitor
    exp_t e;
    int n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("cyc%0d_state", n), 32'(state_o), 32'(e.st));
        check($sformatf("cyc%0d_ctl_st%0d", n, e.st), 32'(act_c), 32'(e.c));
        check($sformatf("cyc%0d_one_gate", n),
              32'($countones({gate_pc, gate_mdr, gate_alu, gate_marmux}) <= 1), 32'(1));
        n++;
      end
    end
  end

  initial begin : main
    logic [3:0] ops[$] = '{4'h1, 4'h5, 4'h9, 4'h0, 4'hC, 4'h4, 4'h2, 4'h6, 4'h3, 4'h7, 4'hE};
    logic [3:0] op;
`ifdef LC3_CTRL_TRAP_EN
    ops.push_back(4'hF);
`endif
    #12;
    check_reset_outputs("in_reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("post_release");

    gen_instr(16'h1283, 1'b0, 0, 0, 0);   // ADD R1,R2,R3
    gen_instr(16'h1283, 1'b0, 3, 0, 0);   // fetch stalls 3 cycles in F2
    gen_instr(16'h4805, 1'b0, 0, 0, 0);   // JSR +5
    gen_instr(16'h0402, 1'b0, 1, 0, 0);   // BR not taken
    gen_instr(16'h0402, 1'b1, 0, 0, 0);   // BR taken
    gen_instr(16'h4080, 1'b0, 0, 0, 0);   // JSRR R2
    gen_instr(16'hC080, 1'b0, 0, 0, 0);   // JMP R2
    gen_instr(16'h2005, 1'b0, 0, 2, 0);   // LD
    gen_instr(16'h6285, 1'b0, 0, 1, 0);   // LDR
    gen_instr(16'h3003, 1'b0, 0, 2, 0);   // ST
    gen_instr(16'h7281, 1'b0, 0, 0, 0);   // STR
    gen_instr(16'hE00A, 1'b0, 0, 0, 0);   // LEA
    gen_instr(16'h5283, 1'b0, 0, 0, 0);   // AND
    gen_instr(16'h927F, 1'b0, 0, 0, 0);   // NOT
    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(0, ops.size() - 1)];
      gen_instr({op, 12'($urandom)}, rnd(), $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    gen_instr(16'hF025, 1'b0, 0, 1, 0);   // TRAP x25, or ILL when TRAP is disabled
`ifdef LC3_CTRL_TRAP_EN
    gen_instr(16'hD123, 1'b0, 0, 0, 0);   // reserved opcode
`endif
    drain();

    // Reset clears the sticky ILL state immediately.
    check("ill_still_held", 32'(illegal), 32'(1));
    rst = 1'b0;
    #1;
    check("ill_cleared_by_reset", 32'(illegal), 32'(0));
    check_reset_outputs("ill_reset");
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-store abandons the write at once.
    gen_instr(16'h3004, 1'b0, 0, 3, 1);
    drain();
    check("sw_busy_before_reset", 32'(mio_en), 32'(1));
    rst = 1'b0;
    #1;
    check("sw_mio_en_dropped", 32'(mio_en), 32'(0));
    check_reset_outputs("sw_reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("sw_release");
    gen_instr(16'h1283, 1'b0, 0, 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
